// File: rtl/fetch_stage.sv
// fetch_stage: fetch-side producer for the fetch/execute boundary.
//
// Holds the fetch PC, issues instruction-memory reads and presents a registered
// {pc, instr, npc} payload with valid toward execute. A one-entry skid register
// catches a completion that lands while execute is stalled. Redirects from
// execute flush the payload and skid; a redirect that arrives while a read is
// still busy goes through SQUASH so the stale response is drained and dropped.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : misaligned redirect targets raise a sticky misaligned_fault and
//               park the FSM in FAULT (no fetch, no valid) until reset.
//   undefined : redirect_pc[1:0] are ignored (forced to 0), no FAULT state.
//
// Ports:
//   CLK, nRST                 clock, async active-low reset
//   imem_ren/imem_addr        read request / word address (held while busy)
//   imem_rdata/imem_busy      read data / wait indication
//   stall_fe                  execute cannot accept the current payload
//   redirect_en/redirect_pc   one-cycle PC redirect from execute
//   valid, pc, instr, npc     registered payload toward execute
//   misaligned_fault          (macro only) sticky misaligned-redirect flag
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busy,
  input  logic        stall_fe,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] npc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misaligned_fault
`endif
);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_SQUASH
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    S_FAULT
`endif
  } state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, tgt_q, tgt_in;
  logic        valid_q, skid_vld;
  logic [31:0] pc_q, instr_q, npc_q, skid_pc, skid_instr;

  // datapath strobes produced by the FSM
  logic flush, ld_out, ld_skid, skid_out, drop_out;
  logic fpc_inc, fpc_redir, fpc_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, bad_tgt, set_fault;
  assign tgt_in  = redirect_pc;
  assign bad_tgt = redirect_pc[1:0] != 2'b00;
  assign misaligned_fault = fault_q;
`else
  assign tgt_in = redirect_pc & ~32'h3;
`endif

  assign imem_addr = fetch_pc;
  assign valid     = valid_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign npc       = npc_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_REQ;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    imem_ren  = 1'b0;
    flush     = 1'b0;
    ld_out    = 1'b0;
    ld_skid   = 1'b0;
    skid_out  = 1'b0;
    drop_out  = 1'b0;
    fpc_inc   = 1'b0;
    fpc_redir = 1'b0;
    fpc_tgt   = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    set_fault = 1'b0;
`endif

    // SQUASH keeps the stale request asserted so the bus can finish it
    if (state == S_REQ || state == S_SQUASH) imem_ren = 1'b1;

`ifdef FETCH_MISALIGN_CHECK_EN
    if (redirect_en && state != S_FAULT) begin
`else
    if (redirect_en) begin
`endif
      flush = 1'b1;
      case (state)
        S_REQ:   if (imem_busy) state_n = S_SQUASH;
                 else           fpc_redir = 1'b1;
        S_HOLD:  begin fpc_redir = 1'b1; state_n = S_REQ; end
        default: ;
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      if (bad_tgt) begin
        set_fault = 1'b1;
        // an outstanding read must still drain before parking
        state_n = (state == S_SQUASH || (state == S_REQ && imem_busy)) ? S_SQUASH : S_FAULT;
      end
`endif
    end else begin
      case (state)
        S_REQ: begin
          if (!imem_busy) begin
            fpc_inc = 1'b1;
            if (!valid_q || !stall_fe) ld_out = 1'b1;
            else begin
              ld_skid = 1'b1;
              state_n = S_HOLD;
            end
          end else if (valid_q && !stall_fe) begin
            drop_out = 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall_fe && skid_vld) begin
            skid_out = 1'b1;
            state_n  = S_REQ;
          end
        end
        S_SQUASH: begin
          if (!imem_busy) begin
            fpc_tgt = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
            state_n = fault_q ? S_FAULT : S_REQ;
`else
            state_n = S_REQ;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc   <= RESET_PC;
      tgt_q      <= 32'h0;
      valid_q    <= 1'b0;
      pc_q       <= 32'h0;
      instr_q    <= 32'h0;
      npc_q      <= 32'h0;
      skid_vld   <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      if (flush) begin
        valid_q  <= 1'b0;
        skid_vld <= 1'b0;
        tgt_q    <= tgt_in;
      end else begin
        if (ld_out) begin
          valid_q <= 1'b1;
          pc_q    <= fetch_pc;
          instr_q <= imem_rdata;
          npc_q   <= fetch_pc + 32'd4;
        end else if (skid_out) begin
          pc_q     <= skid_pc;
          instr_q  <= skid_instr;
          npc_q    <= skid_pc + 32'd4;
          skid_vld <= 1'b0;
        end else if (drop_out) begin
          valid_q <= 1'b0;
        end
        if (ld_skid) begin
          skid_vld   <= 1'b1;
          skid_pc    <= fetch_pc;
          skid_instr <= imem_rdata;
        end
      end
      if (fpc_redir)    fetch_pc <= tgt_in;
      else if (fpc_tgt) fetch_pc <= tgt_q;
      else if (fpc_inc) fetch_pc <= fetch_pc + 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (set_fault) fault_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed boundary cases plus randomized stall/busy/
// redirect traffic. The reference model is the architectural instruction
// stream: consecutive word PCs from the last redirect (or reset), each with
// instr = pc ^ A5A5_A5A5 and npc = pc + 4. Anything not yet handed over when a
// redirect fires is dropped. A negedge monitor pops the stream whenever
// execute takes an instruction and also checks the address-hold rule.
module tb_fetch_stage;
  localparam logic [31:0] K      = 32'hA5A5_A5A5;
  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imem_ren, imem_busy, stall_fe, redirect_en, valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, pc, instr, npc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misaligned_fault;
`endif

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .nRST(nRST),
    .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_busy(imem_busy),
    .stall_fe(stall_fe),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .valid(valid), .pc(pc), .instr(instr), .npc(npc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misaligned_fault(misaligned_fault)
`endif
  );

  always #5 CLK = ~CLK;

  // zero-latency memory image: data is a fixed function of the address
  assign imem_rdata = imem_addr ^ K;

  int          n_vec = 0, n_err = 0, n_deliv = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_next;
  bit          model_dead = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void sb_fill();
    while (!model_dead && exp_q.size() < 4) begin
      exp_q.push_back(model_next);
      model_next = model_next + 32'd4;
    end
  endfunction

  function automatic void sb_restart(input logic [31:0] start);
    exp_q.delete();
    model_next = start;
    sb_fill();
  endfunction

  // Apply inputs just after a rising edge (they act at the next one), update
  // the model for any redirect, then return at the following falling edge.
  task automatic cyc(input bit s, input bit b, input bit r, input logic [31:0] rpc);
    @(posedge CLK); #1;
    stall_fe = s; imem_busy = b; redirect_en = r; redirect_pc = rpc;
    if (r && !model_dead) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) begin
        model_dead = 1'b1;
        exp_q.delete();
      end else
`endif
      sb_restart(rpc & ~32'h3);
    end
    sb_fill();
    @(negedge CLK);
  endtask

  // reset asserted a cycle after the last inputs (possibly mid-request)
  task automatic do_reset();
    @(posedge CLK); #1;
    nRST = 1'b0;
    stall_fe = 1'b0; imem_busy = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    model_dead = 1'b0;
    sb_restart(RST_PC);
    @(negedge CLK);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_npc", npc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_fault", 32'(misaligned_fault), 32'd0);
`endif
    #1 nRST = 1'b1;
    chk("rel_ren", 32'(imem_ren), 32'd1);
    chk("rel_addr", imem_addr, RST_PC);
  endtask

  // scoreboard monitor + address-hold rule
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr, mon_e;
  always @(negedge CLK) begin
    if (!nRST) prev_hold = 1'b0;
    else begin
      if (prev_hold && imem_ren) chk("addr_hold", imem_addr, prev_addr);
      prev_hold = imem_ren && imem_busy;
      prev_addr = imem_addr;
      if (valid && !stall_fe && !redirect_en) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL deliver: got pc %h, expected no instruction", pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_pc", pc, mon_e);
          chk("sb_instr", instr, mon_e ^ K);
          chk("sb_npc", npc, mon_e + 32'd4);
          n_deliv++;
        end
      end
    end
  end

  bit          rs, rb, rr;
  logic [31:0] rt;

  initial begin
    stall_fe = 1'b0; imem_busy = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    model_next = RST_PC;
    do_reset();

    // streaming from reset
    cyc(0, 0, 0, 0);
    chk("s_valid", 32'(valid), 32'd1);
    chk("s_pc", pc, 32'h200);
    chk("s_npc", npc, 32'h204);
    chk("s_addr1", imem_addr, 32'h204);
    cyc(1, 0, 0, 0);
    chk("s_pc2", pc, 32'h204);
    chk("s_addr2", imem_addr, 32'h208);
    // stall: 0x208 lands in the skid, request drops
    cyc(1, 0, 0, 0);
    chk("stall_ren", 32'(imem_ren), 32'd0);
    chk("stall_pc", pc, 32'h204);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("stall_ren2", 32'(imem_ren), 32'd0);
    cyc(0, 0, 0, 0);
    chk("unstall_pc", pc, 32'h208);
    chk("unstall_addr", imem_addr, 32'h20C);
    // busy read squashed by a redirect
    cyc(0, 1, 0, 0);
    chk("b_pc", pc, 32'h20C);
    cyc(0, 1, 1, 32'h1000);
    cyc(0, 1, 0, 0);
    chk("sq_addr", imem_addr, 32'h210);
    chk("sq_valid", 32'(valid), 32'd0);
    cyc(0, 0, 0, 0);
    chk("sq_addr2", imem_addr, 32'h210);
    cyc(0, 0, 0, 0);
    chk("sq_next", imem_addr, 32'h1000);
    chk("sq_valid2", 32'(valid), 32'd0);
    cyc(0, 0, 0, 0);
    chk("sq_pc", pc, 32'h1000);
    // redirect on a zero-wait completion while stalled
    cyc(1, 0, 1, 32'h400);
    chk("rs_pc", pc, 32'h1004);
    cyc(0, 0, 0, 0);
    chk("rs_valid", 32'(valid), 32'd0);
    chk("rs_addr", imem_addr, 32'h400);
    cyc(0, 0, 0, 0);
    chk("rs_pc2", pc, 32'h400);
    // wrap at the top of the address space
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("w_pc", pc, 32'hFFFF_FFFC);
    chk("w_npc", npc, 32'h0);
    chk("w_addr2", imem_addr, 32'h0);
    // misaligned redirect
    cyc(0, 0, 1, 32'h1002);
    cyc(0, 0, 0, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      chk("f_fault", 32'(misaligned_fault), 32'd1);
      chk("f_ren", 32'(imem_ren), 32'd0);
      chk("f_valid", 32'(valid), 32'd0);
      cyc(0, 0, 0, 0);
    end
`else
    chk("m_addr", imem_addr, 32'h1000);
    cyc(0, 0, 0, 0);
    chk("m_pc", pc, 32'h1000);
`endif

    // reset in the middle of a busy request
    cyc(0, 1, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0);
    chk("r2_pc", pc, RST_PC);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 99) < 30);
      rb = ($urandom_range(0, 99) < 30);
      rr = ($urandom_range(0, 99) < 4);
      rt = $urandom;
      if ($urandom_range(0, 7) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
`ifdef FETCH_MISALIGN_CHECK_EN
      rt = rt & ~32'h3;
`endif
      cyc(rs, rb, rr, rt);
    end
    chk("deliveries", 32'(n_deliv > 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
